// File: rtl/muldiv_iter_unit.sv
// ============================================================================
//  Module   : muldiv_iter_unit
//  Purpose  : Iterative RV32M multiply/divide unit (shift-add / restoring).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter_unit #(
    parameter int          XLEN      = 32,
    parameter logic [4:0]  OP_MUL    = 5'b00010,
    parameter logic [4:0]  OP_MULH   = 5'b00011,
    parameter logic [4:0]  OP_MULHSU = 5'b00100,
    parameter logic [4:0]  OP_MULHU  = 5'b00101,
    parameter logic [4:0]  OP_DIV    = 5'b00110,
    parameter logic [4:0]  OP_DIVU   = 5'b00111,
    parameter logic [4:0]  OP_REM    = 5'b01000,
    parameter logic [4:0]  OP_REMU   = 5'b01001
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [4:0]      alu_ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_count;
    logic [4:0]        r_op;
    logic              r_is_div;
    logic              r_neg;
    logic              r_div0;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_is_div;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_final;

    assign w_accept   = (r_state == S_IDLE) && start && !kill
                        && (alu_ctl >= OP_MUL) && (alu_ctl <= OP_REMU);
    assign w_is_div   = (alu_ctl >= OP_DIV);
    assign w_a_signed = (alu_ctl == OP_MULH) || (alu_ctl == OP_MULHSU)
                        || (alu_ctl == OP_DIV) || (alu_ctl == OP_REM);
    assign w_b_signed = (alu_ctl == OP_MULH) || (alu_ctl == OP_DIV) || (alu_ctl == OP_REM);
    assign w_a_neg    = w_a_signed && op_a[XLEN-1];
    assign w_b_neg    = w_b_signed && op_b[XLEN-1];
    assign w_mag_a    = w_a_neg ? -op_a : op_a;
    assign w_mag_b    = w_b_neg ? -op_b : op_b;

    // Multiply: {r_acc, r_lo} is the product register, multiplier enters in r_lo.
    assign w_mul_sum  = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    // Divide: r_lo shifts the dividend out and the quotient in.
    assign w_shift    = {r_acc, r_lo[XLEN-1]};
    assign w_trial    = w_shift - {1'b0, r_mcand};

    assign w_prod_s   = r_neg ? -{r_acc, r_lo} : {r_acc, r_lo};
    assign w_quo_s    = r_neg ? -r_lo  : r_lo;
    assign w_rem_s    = r_neg ? -r_acc : r_acc;

    always_comb begin
        w_final = '0;
        case (r_op)
            OP_MUL:                       w_final = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = r_div0 ? '1 : w_quo_s;
            OP_REM, OP_REMU:              w_final = w_rem_s;
            default:                      w_final = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_RUN;
            S_RUN:    if (kill) w_next = S_IDLE;
                      else if (r_count == C_LAST) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_op     <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_div0   <= 1'b0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_op     <= alu_ctl;
            r_is_div <= w_is_div;
            r_neg    <= ((alu_ctl == OP_REM) || (alu_ctl == OP_REMU)) ? w_a_neg
                                                                      : (w_a_neg ^ w_b_neg);
            r_div0   <= (op_b == '0);
            r_acc    <= '0;
            r_lo     <= w_is_div ? w_mag_a : w_mag_b;
            r_mcand  <= w_is_div ? w_mag_b : w_mag_a;
        end else if (r_state == S_RUN) begin
            r_count <= kill ? '0 : r_count + 1'b1;
            if (r_is_div) begin
                if (!w_trial[XLEN]) begin
                    r_acc <= w_trial[XLEN-1:0];
                    r_lo  <= {r_lo[XLEN-2:0], 1'b1};
                end else begin
                    r_acc <= w_shift[XLEN-1:0];
                    r_lo  <= {r_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                r_acc <= w_mul_sum[XLEN:1];
                r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
        end else if (done) begin
            r_result <= w_final;
        end
    end

    // A kill during FINISH still has to suppress done and the result update.
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FINISH) && !kill;
    assign result = done ? w_final : r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_iter_unit.sv
// ============================================================================
//  Module   : tb_muldiv_iter_unit
//  Purpose  : Bench for muldiv_iter_unit: directed vectors plus random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_iter_unit;

    localparam logic [4:0] OP_MUL    = 5'b00010;
    localparam logic [4:0] OP_MULH   = 5'b00011;
    localparam logic [4:0] OP_MULHSU = 5'b00100;
    localparam logic [4:0] OP_MULHU  = 5'b00101;
    localparam logic [4:0] OP_DIV    = 5'b00110;
    localparam logic [4:0] OP_DIVU   = 5'b00111;
    localparam logic [4:0] OP_REM    = 5'b01000;
    localparam logic [4:0] OP_REMU   = 5'b01001;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [4:0]  alu_ctl;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int          m_left   = 0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend   = '0;

    muldiv_iter_unit dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .alu_ctl(alu_ctl),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0]        pu;
        logic signed [63:0] ps;
        logic signed [31:0] sa, sb, sq;
        bit                 ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        pu  = {32'b0, a} * {32'b0, b};
        case (op)
            OP_MUL:    return pu[31:0];
            OP_MULHU:  return pu[63:32];
            OP_MULH: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return ps[63:32];
            end
            OP_MULHSU: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                return ps[63:32];
            end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                sq = sa / sb;
                return sq;
            end
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                sq = sa % sb;
                return sq;
            end
            OP_REMU:   return (b == 0) ? a : a % b;
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: 33 busy cycles after an accept, result in the last one.
    always @(posedge clk) begin
        if (rst) begin
            m_left   <= 0;
            m_result <= '0;
        end else if (m_left == 0) begin
            if (start && !kill && alu_ctl >= OP_MUL && alu_ctl <= OP_REMU) begin
                m_pend <= ref_op(alu_ctl, op_a, op_b);
                m_left <= 33;
            end
        end else if (kill) begin
            m_left <= 0;
        end else begin
            if (m_left == 1) m_result <= m_pend;
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_done;
            exp_done = (m_left == 1) && !kill;
            chk("busy",   {31'b0, busy}, {31'b0, (m_left > 0)});
            chk("done",   {31'b0, done}, {31'b0, exp_done});
            chk("result", result, exp_done ? m_pend : m_result);
        end
    end

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lit);
        int n;
        chk({"model_", name}, ref_op(op, a, b), exp_lit);
        @(posedge clk); #1;
        start = 1'b1; alu_ctl = op; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; alu_ctl = 5'($urandom);
        n = 1;
        @(negedge clk);
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({"latency_", name}, 32'(n), 32'd33);
        chk({"value_", name}, result, exp_lit);
        @(negedge clk);
        chk({"idle_after_", name}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; alu_ctl = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy",   {31'b0, busy}, 32'd0);
        chk("reset_done",   {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;

        run_op("mul",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh",   OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
        run_op("div",    OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("rem",    OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("divu",   OP_DIVU,   32'd100,        32'd7,         32'd14);
        run_op("remu",   OP_REMU,   32'd100,        32'd7,         32'd2);
        run_op("div0",   OP_DIV,    32'h1234,       32'd0,         32'hFFFF_FFFF);
        run_op("rem0",   OP_REM,    32'h1234,       32'd0,         32'h1234);
        run_op("divovf", OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("removf", OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0);
        run_op("divu2",  OP_DIVU,   32'd100,        32'd7,         32'd14);

        // Kill at T+10 with an ignored second start at T+5.
        @(posedge clk); #1;
        start = 1'b1; alu_ctl = OP_DIVU; op_a = 32'd1000; op_b = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start   = (c == 5);
            alu_ctl = OP_MUL;
            kill    = (c == 10);
        end
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_busy",   {31'b0, busy}, 32'd0);
        chk("kill_result", result, 32'd14);
        repeat (40) @(posedge clk);

        // Unsupported op code is ignored.
        #1;
        start = 1'b1; alu_ctl = 5'b00000; op_a = 32'd5; op_b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("badop_busy", {31'b0, busy}, 32'd0);

        // Reset mid-run.
        @(posedge clk); #1;
        start = 1'b1; alu_ctl = OP_MULHU; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",   {31'b0, busy}, 32'd0);
        chk("rst_done",   {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        run_op("after_rst", OP_REMU, 32'd1000, 32'd7, 32'd6);

        // Random traffic, including kills, starts while busy and rare resets.
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            rst     = ($urandom_range(0, 799) == 0);
            start   = ($urandom_range(0, 3) == 0);
            kill    = ($urandom_range(0, 149) == 0);
            alu_ctl = 5'($urandom_range(0, 11));
            op_a    = pick();
            op_b    = pick();
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; kill = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
